// File: rtl/path_delay_sequencer.sv
// path_delay_sequencer
//
// Measurement controller for the delay-chain spy paths. It selects one path,
// launches alternating 0/1 transitions into it, and samples the path output a
// programmable number of clock edges after each launch. Trials whose output has
// not reached the expected level at the capture edge are counted as timing
// failures.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   start, abort    run request (accepted only when idle) / run termination
//   path_sel        path under test (latched at start)
//   exp_invert      1 = path output is the inverse of its launch level
//   trials          launches per run
//   settle_cycles   cycles the launch level is held before each launch
//   sample_cycles   edges from launch edge to capture edge
//   path_launch     launch drive, one bit per path (only the selected bit moves)
//   path_result     path outputs
//   busy, done      run in progress / one-cycle end-of-run pulse
//   error           run rejected because path_sel was out of range
//   stuck           path output disagreed with the held level at end of a settle
//   fail_count      timing failures in the last or current run
//   trial_count     trials completed
module path_delay_sequencer #(
    parameter int unsigned NUM_PATHS = 4,
    parameter int unsigned SEL_W     = 2,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned WAIT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [SEL_W-1:0]     path_sel,
    input  logic                 exp_invert,
    input  logic [CNT_W-1:0]     trials,
    input  logic [WAIT_W-1:0]    settle_cycles,
    input  logic [WAIT_W-1:0]    sample_cycles,
    output logic [NUM_PATHS-1:0] path_launch,
    input  logic [NUM_PATHS-1:0] path_result,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic                 stuck,
    output logic [CNT_W-1:0]     fail_count,
    output logic [CNT_W-1:0]     trial_count
);

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StWait,
        StEval,
        StDone
    } state_e;

    state_e                 state_q,  state_d;
    logic                   lvl_q,    lvl_d;
    logic [SEL_W-1:0]       sel_q,    sel_d;
    logic                   inv_q,    inv_d;
    logic [CNT_W-1:0]       trials_q, trials_d;
    logic [WAIT_W-1:0]      settle_q, settle_d;
    logic [WAIT_W-1:0]      sample_q, sample_d;
    logic [WAIT_W-1:0]      cnt_q,    cnt_d;
    logic                   cap_q,    cap_d;
    logic [CNT_W-1:0]       fail_q,   fail_d;
    logic [CNT_W-1:0]       trial_q,  trial_d;
    logic                   busy_q,   busy_d;
    logic                   done_q,   done_d;
    logic                   error_q,  error_d;
    logic                   stuck_q,  stuck_d;
    logic [NUM_PATHS-1:0]   launch_q, launch_d;

    logic res_bit;
    logic exp_lvl;
    logic sel_ok;

    // Down-counter load value: a zero length behaves as one cycle.
    function automatic logic [WAIT_W-1:0] len_m1(input logic [WAIT_W-1:0] v);
        return (v == '0) ? '0 : v - WAIT_W'(1);
    endfunction

    always_comb begin
        res_bit = 1'b0;
        for (int i = 0; i < NUM_PATHS; i++) begin
            if (sel_q == SEL_W'(i)) begin
                res_bit = path_result[i];
            end
        end
    end

    assign exp_lvl = lvl_q ^ inv_q;
    assign sel_ok  = (32'(path_sel) < NUM_PATHS);

    always_comb begin
        state_d  = state_q;
        lvl_d    = lvl_q;
        sel_d    = sel_q;
        inv_d    = inv_q;
        trials_d = trials_q;
        settle_d = settle_q;
        sample_d = sample_q;
        cnt_d    = cnt_q;
        cap_d    = cap_q;
        fail_d   = fail_q;
        trial_d  = trial_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        error_d  = error_q;
        stuck_d  = stuck_q;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    sel_d    = path_sel;
                    inv_d    = exp_invert;
                    trials_d = trials;
                    settle_d = settle_cycles;
                    sample_d = sample_cycles;
                    fail_d   = '0;
                    trial_d  = '0;
                    stuck_d  = 1'b0;
                    error_d  = 1'b0;
                    lvl_d    = 1'b0;
                    busy_d   = 1'b1;
                    if (!sel_ok) begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else if (trials == '0) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        cnt_d   = len_m1(settle_cycles);
                        state_d = StSettle;
                    end
                end
            end
            StSettle: begin
                if (cnt_q == '0) begin
                    if (res_bit != exp_lvl) begin
                        stuck_d = 1'b1;
                    end
                    // Launch edge: the held level flips as we leave SETTLE.
                    lvl_d   = ~lvl_q;
                    cnt_d   = len_m1(sample_q);
                    state_d = StWait;
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    cap_d   = res_bit;
                    state_d = StEval;
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            StEval: begin
                if ((cap_q != exp_lvl) && (fail_q != '1)) begin
                    fail_d = fail_q + CNT_W'(1);
                end
                trial_d = trial_q + CNT_W'(1);
                if (trial_d == trials_q) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d   = len_m1(settle_q);
                    state_d = StSettle;
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase

        // Abort discards the in-flight trial; completed counts are kept.
        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            fail_d  = fail_q;
            trial_d = trial_q;
            stuck_d = stuck_q;
        end
    end

    // Only the selected bit carries the launch level, and only while busy.
    always_comb begin
        launch_d = '0;
        if (busy_d) begin
            for (int i = 0; i < NUM_PATHS; i++) begin
                if (sel_d == SEL_W'(i)) begin
                    launch_d[i] = lvl_d;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            lvl_q    <= 1'b0;
            sel_q    <= '0;
            inv_q    <= 1'b0;
            trials_q <= '0;
            settle_q <= '0;
            sample_q <= '0;
            cnt_q    <= '0;
            cap_q    <= 1'b0;
            fail_q   <= '0;
            trial_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            stuck_q  <= 1'b0;
            launch_q <= '0;
        end else begin
            state_q  <= state_d;
            lvl_q    <= lvl_d;
            sel_q    <= sel_d;
            inv_q    <= inv_d;
            trials_q <= trials_d;
            settle_q <= settle_d;
            sample_q <= sample_d;
            cnt_q    <= cnt_d;
            cap_q    <= cap_d;
            fail_q   <= fail_d;
            trial_q  <= trial_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
            stuck_q  <= stuck_d;
            launch_q <= launch_d;
        end
    end

    assign path_launch = launch_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign stuck       = stuck_q;
    assign fail_count  = fail_q;
    assign trial_count = trial_q;

endmodule

// File: tb/tb_path_delay_sequencer.sv
module tb_path_delay_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [1:0]  path_sel;
    logic        exp_invert;
    logic [15:0] trials;
    logic [7:0]  settle_cycles;
    logic [7:0]  sample_cycles;
    logic [3:0]  path_launch;
    logic [3:0]  path_result;
    logic        busy, done, error, stuck;
    logic [15:0] fail_count, trial_count;

    // Second instance with three paths, to exercise an out-of-range select.
    logic [2:0]  path_launch3;
    logic        busy3, done3, error3, stuck3;
    logic [15:0] fail_count3, trial_count3;

    int vectors;
    int miscompares;
    int tog;
    logic [3:0] seen;
    logic last_l;

    // Path model: 0 = launch delayed by 'delay' cycles, 1 = inverted launch, 2 = stuck at 0.
    int mode;
    int delay;
    logic [3:0] hist [0:7];

    path_delay_sequencer #(
        .NUM_PATHS(4), .SEL_W(2), .CNT_W(16), .WAIT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .path_sel(path_sel), .exp_invert(exp_invert), .trials(trials),
        .settle_cycles(settle_cycles), .sample_cycles(sample_cycles),
        .path_launch(path_launch), .path_result(path_result),
        .busy(busy), .done(done), .error(error), .stuck(stuck),
        .fail_count(fail_count), .trial_count(trial_count)
    );

    path_delay_sequencer #(
        .NUM_PATHS(3), .SEL_W(2), .CNT_W(16), .WAIT_W(8)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .path_sel(path_sel), .exp_invert(exp_invert), .trials(trials),
        .settle_cycles(settle_cycles), .sample_cycles(sample_cycles),
        .path_launch(path_launch3), .path_result(path_result[2:0]),
        .busy(busy3), .done(done3), .error(error3), .stuck(stuck3),
        .fail_count(fail_count3), .trial_count(trial_count3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        hist[0] <= path_launch;
        for (int i = 1; i < 8; i++) hist[i] <= hist[i-1];
    end

    always_comb begin
        path_result = 4'b0000;
        case (mode)
            0:       path_result = hist[delay-1];
            1:       path_result = ~path_launch;
            default: path_result = 4'b0000;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n cycles, sampling on the falling edge and tracking launch activity.
    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (path_launch[1] !== last_l) tog++;
            last_l = path_launch[1];
            seen = seen | path_launch;
        end
    endtask

    task automatic run_start();
        tog = 0;
        seen = 4'b0000;
        last_l = path_launch[1];
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    initial begin
        vectors = 0; miscompares = 0; tog = 0; seen = 4'b0000; last_l = 1'b0;
        mode = 0; delay = 1;
        for (int i = 0; i < 8; i++) hist[i] = 4'b0000;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; path_sel = 2'd1; exp_invert = 1'b0;
        trials = 16'd4; settle_cycles = 8'd3; sample_cycles = 8'd2;

        // Reset state
        #12;
        chk("rst_launch", 32'(path_launch), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_counts", 32'({fail_count, trial_count}), 0);
        rst_n = 1'b1;
        cyc(8);

        // Test 1: delay 1, sel 1, 4 trials, settle 3, sample 2; stray start mid-run
        run_start();
        cyc(3);
        path_sel = 2'd2; start = 1'b1;
        cyc(1);
        start = 1'b0; path_sel = 2'd1;
        cyc(19);
        chk("t1_done_early", 32'(done), 0);
        chk("t1_busy", 32'(busy), 1);
        cyc(1);
        chk("t1_done", 32'(done), 1);
        chk("t1_fail", 32'(fail_count), 0);
        chk("t1_trial", 32'(trial_count), 4);
        chk("t1_stuck", 32'(stuck), 0);
        chk("t1_toggles", 32'(tog), 4);
        chk("t1_seen", 32'(seen), 2);
        cyc(1);
        chk("t1_done_pulse", 32'(done), 0);
        chk("t1_idle_busy", 32'(busy), 0);
        chk("t1_idle_launch", 32'(path_launch), 0);
        cyc(8);

        // Test 2: delay 5 with sample 2 fails every trial
        delay = 5;
        cyc(8);
        run_start();
        cyc(24);
        chk("t2_done", 32'(done), 1);
        chk("t2_fail", 32'(fail_count), 4);
        chk("t2_stuck", 32'(stuck), 0);
        cyc(8);

        // Test 2b: sample 6 covers the 5-cycle delay
        sample_cycles = 8'd6;
        run_start();
        cyc(40);
        chk("t2b_done", 32'(done), 1);
        chk("t2b_fail", 32'(fail_count), 0);
        chk("t2b_trial", 32'(trial_count), 4);
        chk("t2b_stuck", 32'(stuck), 0);
        cyc(8);

        // Test 3: inverting path, zero settle/sample lengths, 3 trials
        mode = 1; exp_invert = 1'b1; settle_cycles = 8'd0; sample_cycles = 8'd0;
        trials = 16'd3;
        run_start();
        cyc(8);
        chk("t3_done_early", 32'(done), 0);
        cyc(1);
        chk("t3_done", 32'(done), 1);
        chk("t3_fail", 32'(fail_count), 0);
        chk("t3_trial", 32'(trial_count), 3);
        chk("t3_stuck", 32'(stuck), 0);
        cyc(8);

        // Test 4: sel 3 (invalid for 3 paths, valid for 4) with trials 0
        mode = 0; delay = 1; exp_invert = 1'b0; path_sel = 2'd3; trials = 16'd0;
        settle_cycles = 8'd3; sample_cycles = 8'd2;
        cyc(8);
        run_start();
        chk("t4_done3", 32'(done3), 1);
        chk("t4_error3", 32'(error3), 1);
        chk("t4_launch3", 32'(path_launch3), 0);
        chk("t4_done", 32'(done), 1);
        chk("t4_error", 32'(error), 0);
        chk("t4_counts", 32'({fail_count, trial_count}), 0);
        cyc(1);
        chk("t4_error3_hold", 32'({done3, error3}), 1);
        chk("t4_busy3", 32'(busy3), 0);
        cyc(4);

        // Test 5: abort during WAIT of trial 2
        path_sel = 2'd1; trials = 16'd4;
        run_start();
        cyc(9);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_done", 32'(done), 0);
        chk("t5_launch", 32'(path_launch), 0);
        chk("t5_trial", 32'(trial_count), 1);
        cyc(3);
        chk("t5_no_done", 32'({busy, done}), 0);

        // start together with abort in IDLE is ignored
        start = 1'b1; abort = 1'b1;
        cyc(1);
        start = 1'b0; abort = 1'b0;
        chk("t5b_busy", 32'(busy), 0);
        cyc(2);
        chk("t5b_idle", 32'({busy, done}), 0);
        chk("t5b_trial_kept", 32'(trial_count), 1);
        cyc(8);

        // Test 6: path output stuck at 0, 2 trials
        mode = 2; trials = 16'd2; settle_cycles = 8'd2; sample_cycles = 8'd2;
        run_start();
        cyc(10);
        chk("t6_done", 32'(done), 1);
        chk("t6_stuck", 32'(stuck), 1);
        chk("t6_fail", 32'(fail_count), 1);
        chk("t6_trial", 32'(trial_count), 2);
        cyc(8);

        // Test 7: asynchronous reset mid-run
        mode = 0; delay = 1; trials = 16'd4; settle_cycles = 8'd3; sample_cycles = 8'd4;
        run_start();
        cyc(4);
        chk("t7_launch_hi", 32'(path_launch), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_rst_launch", 32'(path_launch), 0);
        chk("t7_rst_busy", 32'(busy), 0);
        chk("t7_rst_trial", 32'(trial_count), 0);
        chk("t7_rst_flags", 32'({done, error, stuck}), 0);
        #4 rst_n = 1'b1;
        cyc(2);
        chk("t7_after_busy", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
